// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 12-bit/8-bit memory port between fetch, load/store and debug.
// Runs a fixed MEM_LAT-cycle access per grant; all outputs are registered.
module mem_port_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [11:0] addr2,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    input  logic [7:0]  wdata2,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [7:0]  rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  gnt_q, gnt_d;
    logic [2:0]  done_q, done_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        rd_q, rd_d;
    logic        we_q, we_d;

    logic [1:0]  cand [3];
    logic [1:0]  win;
    logic        win_vld;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2 || i == 2'd3) ? 2'd0 : i + 2'd1;
    endfunction

    // Candidates in priority order starting after the last served requester.
    always_comb begin
        cand[0] = next_idx(last_q);
        cand[1] = next_idx(cand[0]);
        cand[2] = next_idx(cand[1]);
        win     = 2'd0;
        win_vld = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (req[cand[k]]) begin
                win     = cand[k];
                win_vld = 1'b1;
            end
        end
    end

    // NOTE: asynchronous reset clears every register, so an access cut short by
    // reset can never produce a late done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 2'd2;
            gnt_q   <= '0;
            done_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (win_vld) state_d = ACCESS;
            ACCESS:  if (cnt_q == CNT_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        we_d    = we_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d  = 3'b001 << win;
                    last_d = win;
                    cnt_d  = '0;
                    we_d   = we[win];
                    rd_d   = ~we[win];
                    unique case (win)
                        2'd0: begin
                            addr_d  = addr0;
                            wdata_d = wdata0;
                        end
                        2'd1: begin
                            addr_d  = addr1;
                            wdata_d = wdata1;
                        end
                        default: begin
                            addr_d  = addr2;
                            wdata_d = wdata2;
                        end
                    endcase
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    if (rd_q) rdata_d = mem_rdata;
                    rd_d   = 1'b0;
                    we_d   = 1'b0;
                    done_d = gnt_q;
                end
            end
            FINISH: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
                rd_d  = 1'b0;
                we_d  = 1'b0;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd    = rd_q;
    assign mem_we    = we_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=1 instances share stimulus and are
// compared every cycle against a transaction-phase reference model with its own memory image.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we;
    logic [11:0] addr0, addr1, addr2;
    logic [7:0]  wdata0, wdata1, wdata2;

    logic [1:0][7:0]  mem_rdata;
    logic [1:0][2:0]  gnt_w, done_w;
    logic [1:0][11:0] mem_addr_w;
    logic [1:0][7:0]  mem_wdata_w, rdata_w;
    logic [1:0]       mem_rd_w, mem_we_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          phase;
        int          w;
        int          last;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [7:0]  rdata;
    } model_t;

    model_t     m [2];
    int         lat [2];
    int         rd_cycles [2];
    logic [7:0] ram [2][4096];
    logic [7:0] ref_ram [2][4096];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .mem_rdata(mem_rdata[0]), .gnt(gnt_w[0]), .done(done_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
        .mem_rd(mem_rd_w[0]), .mem_we(mem_we_w[0]), .rdata(rdata_w[0])
    );

    mem_port_arbiter #(.MEM_LAT(1)) dut_lat1 (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .mem_rdata(mem_rdata[1]), .gnt(gnt_w[1]), .done(done_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
        .mem_rd(mem_rd_w[1]), .mem_we(mem_we_w[1]), .rdata(rdata_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] addr_of(input int w);
        return (w == 0) ? addr0 : (w == 1) ? addr1 : addr2;
    endfunction

    function automatic logic [7:0] wdata_of(input int w);
        return (w == 0) ? wdata0 : (w == 1) ? wdata1 : wdata2;
    endfunction

    // Phase 0 = idle, 1..lat = access cycles, lat+1 = completion cycle.
    task automatic model_step(input int k);
        int c;
        if (rst) begin
            m[k].phase = 0;
            m[k].w     = 0;
            m[k].last  = 2;
            m[k].addr  = '0;
            m[k].wdata = '0;
            m[k].wr    = 1'b0;
            m[k].rdata = '0;
        end else if (m[k].phase == 0) begin
            if (req != 3'b000) begin
                for (int i = 1; i <= 3; i++) begin
                    c = (m[k].last + i) % 3;
                    if (req[c]) begin
                        m[k].w = c;
                        break;
                    end
                end
                m[k].phase = 1;
                m[k].last  = m[k].w;
                m[k].addr  = addr_of(m[k].w);
                m[k].wdata = wdata_of(m[k].w);
                m[k].wr    = we[m[k].w];
                if (m[k].wr) ref_ram[k][m[k].addr] = m[k].wdata;
            end
        end else if (m[k].phase <= lat[k]) begin
            if (m[k].phase == lat[k] && !m[k].wr) m[k].rdata = ref_ram[k][m[k].addr];
            m[k].phase++;
        end else begin
            m[k].phase = 0;
        end
    endtask

    task automatic check_all(input int k);
        logic [2:0] sel;
        logic       busy;
        string      p;
        p    = $sformatf("lat%0d", lat[k]);
        sel  = 3'b001 << m[k].w;
        busy = (m[k].phase >= 1) && (m[k].phase <= lat[k]);
        check({p, " gnt"},       gnt_w[k],       (m[k].phase != 0) ? sel : 3'b000);
        check({p, " done"},      done_w[k],      (m[k].phase == lat[k] + 1) ? sel : 3'b000);
        check({p, " mem_rd"},    mem_rd_w[k],    busy && !m[k].wr);
        check({p, " mem_we"},    mem_we_w[k],    busy && m[k].wr);
        check({p, " mem_addr"},  mem_addr_w[k],  m[k].addr);
        check({p, " mem_wdata"}, mem_wdata_w[k], m[k].wdata);
        check({p, " rdata"},     rdata_w[k],     m[k].rdata);
    endtask

    // Memory returns valid data only in the lat-th cycle of a read strobe, junk otherwise.
    task automatic mem_drive(input int k);
        if (mem_we_w[k]) ram[k][mem_addr_w[k]] = mem_wdata_w[k];
        rd_cycles[k] = mem_rd_w[k] ? rd_cycles[k] + 1 : 0;
        mem_rdata[k] = (rd_cycles[k] == lat[k]) ? ram[k][mem_addr_w[k]] : 8'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_all(k);
            mem_drive(k);
        end
    endtask

    task automatic idle(input int n);
        req = 3'b000;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        lat[0] = 2;
        lat[1] = 1;
        rst = 1'b1;
        req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        mem_rdata = '0;
        for (int k = 0; k < 2; k++) begin
            rd_cycles[k] = 0;
            for (int a = 0; a < 4096; a++) begin
                ram[k][a]     = 8'(a * 7 + 3);
                ref_ram[k][a] = 8'(a * 7 + 3);
            end
            ram[k][12'h0A5]     = 8'h3C;
            ref_ram[k][12'h0A5] = 8'h3C;
            model_step(k);
        end
        tick();
        tick();
        rst = 1'b0;

        // Single read, with req0 and addr0 changing once the access is under way.
        req = 3'b001; we = 3'b000; addr0 = 12'h0A5;
        tick();
        req = 3'b000; addr0 = 12'h123;
        tick();
        tick();
        check("read done", done_w[0], 3'b001);
        check("read rdata", rdata_w[0], 8'h3C);
        idle(2);

        // Write: rdata must keep the value from the read.
        req = 3'b010; we = 3'b010; addr1 = 12'hFFF; wdata1 = 8'h81;
        tick();
        req = 3'b000;
        tick();
        tick();
        check("write done", done_w[0], 3'b010);
        check("write rdata kept", rdata_w[0], 8'h3C);
        idle(3);

        // All three requesting continuously.
        req = 3'b111; we = 3'b000;
        for (int i = 0; i < 24; i++) tick();
        idle(4);

        // Asynchronous reset in the second access cycle of the MEM_LAT=2 instance.
        req = 3'b001; we = 3'b000; addr0 = 12'h0A5;
        tick();
        req = 3'b000;
        tick();
        #2 rst = 1'b1;
        #1;
        check("async rst gnt", gnt_w[0], 3'b000);
        check("async rst rd", mem_rd_w[0], 1'b0);
        check("async rst rdata", rdata_w[0], 8'h00);
        check("async rst done", done_w[0], 3'b000);
        tick();
        rst = 1'b0;
        req = 3'b100; we = 3'b000; addr2 = 12'h001;
        tick();
        check("post rst gnt", gnt_w[0], 3'b100);
        check("post rst gnt lat1", gnt_w[1], 3'b100);
        for (int i = 0; i < 8; i++) tick();
        idle(4);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 399) == 0);
            req    = 3'($urandom);
            we     = 3'($urandom);
            addr0  = 12'($urandom_range(0, 31));
            addr1  = 12'($urandom_range(0, 31));
            addr2  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31));
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            wdata2 = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single 12-bit-address / 8-bit-data memory port between three requesters:
  - 0 = instruction fetch
  - 1 = data load/store
  - 2 = debug/DMA
- Runs a fixed-latency access sequence on that port.
- Drives the one-hot `gnt` vector, which feeds the select inputs of the 3-to-1 address and write-data muxes.
- Round-robin fairness. At most one access in flight.

## Interface

Parameters:
- `MEM_LAT`, default 2 — cycles the memory needs from address/strobe to valid `mem_rdata`; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1 — rising-edge clock
- `rst`  in  1 — asynchronous, active-high reset
- `req`  in  3 — per-requester access request, level
- `we`  in  3 — per-requester write intent (1 = write, 0 = read), valid with `req`
- `addr0`, `addr1`, `addr2`  in  12 each — requester addresses
- `wdata0`, `wdata1`, `wdata2`  in  8 each — requester write data
- `mem_rdata`  in  8 — memory read data
- `gnt`  out  3 — one-hot grant; also the mux selects (bit0 = first, bit1 = second, bit2 = third)
- `done`  out  3 — one-cycle completion pulse to the granted requester
- `mem_addr`  out  12 — latched address of the granted requester
- `mem_wdata`  out  8 — latched write data
- `mem_rd`  out  1 — read strobe
- `mem_we`  out  1 — write strobe
- `rdata`  out  8 — captured read data, held until the next read completes

## Operation

- **States:**
  - `IDLE`
  - `ACCESS`
  - `FINISH`
- **Transitions:**
  - `IDLE` → `ACCESS` when `req != 0`; arbitration happens only in `IDLE`.
  - `ACCESS` → `FINISH` when the latency counter reaches `MEM_LAT-1`.
  - `FINISH` → `IDLE` unconditionally.
- **Round-robin arbitration:**
  - Priority order starts at `last+1` (mod 3), where `last` is the index of the last served requester.
  - `last` updates on every grant.
  - Reset value of `last` = 2, so the first priority order is 0, 1, 2.
- **On grant (`IDLE` edge):**
  - Register `gnt` one-hot.
  - Register `mem_addr`/`mem_wdata` from the winner's `addrN`/`wdataN`.
  - Register `mem_we = we[i]` and `mem_rd = ~we[i]`.
  - Clear the counter.
- **During `ACCESS`:**
  - Address, data and strobe are held stable; requester inputs are ignored.
  - The 4-bit counter increments each cycle.
- **Last `ACCESS` edge:**
  - On a read, `rdata <= mem_rdata`.
  - On a write, `rdata` is unchanged.
  - `mem_rd`/`mem_we` drop to 0.
- **`FINISH`:** `done[i] = 1` for exactly one cycle; `gnt` stays asserted.
- **Leaving `FINISH`:** `gnt` clears to 0 and `done` clears to 0.
- **Requester contract:** hold `req[i]` until `done[i]`.
  - Dropping `req[i]` mid-access does not abort it; the access and `done` still complete.
  - A requester still asserting `req` after `done` is treated as a new request.
- **Invariants:**
  - `gnt` is one-hot or zero at all times.
  - `gnt` never changes in `ACCESS` or `FINISH`.
  - `mem_rd & mem_we` is never 1.
- **Reset (async, any state, including mid-access):**
  - state = `IDLE`
  - `gnt` = 0, `done` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
  - `mem_rd` = 0, `mem_we` = 0
  - `rdata` = 0, counter = 0, `last` = 2
  - An interrupted access produces no `done`.

## Timing

- **Cycle T:** `req` is sampled high in `IDLE`.
- **T+1 .. T+MEM_LAT:** `ACCESS`; `gnt`, `mem_addr` and the strobe are valid.
- **T+MEM_LAT+1:** `FINISH`; `done` pulses and `rdata` is valid.
- **T+MEM_LAT+2:** `IDLE`; the next arbitration is sampled at this edge.
- **Throughput:** one access per `MEM_LAT+2` cycles; latency from `req` to `done` is `MEM_LAT+1` cycles.
- **`MEM_LAT=1`:** single `ACCESS` cycle; the counter compares against 0.
- **Simultaneous requests:** resolved purely by round-robin. No starvation: a continuously requesting port is served within 3 grants.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Test plan

- **Single read:** `MEM_LAT=2`; after reset, `req=001`, `we=000`, `addr0=0x0A5`, memory returns `0x3C`.
  - `gnt=001` in cycles 1–3.
  - `mem_rd=1` and `mem_addr=0x0A5` in cycles 1–2.
  - `done=001` and `rdata=0x3C` in cycle 3.
  - `gnt=000` in cycle 4.
- **Write:** `req=010`, `we=010`, `addr1=0xFFF`, `wdata1=0x81`.
  - `mem_we=1`, `mem_addr=0xFFF` and `mem_wdata=0x81` for 2 cycles.
  - `mem_rd=0` throughout.
  - `rdata` keeps its prior value.
  - `done=010` once.
- **Round-robin:** `req=111` held continuously.
  - Grant order from reset is 0, 1, 2, 0, 1, 2.
  - Successive grants are 4 cycles apart.
  - `gnt` is never multi-hot.
- **Mid-access input change:** `addr0` and `req0` change during `ACCESS`.
  - `mem_addr` is unchanged.
  - `done=001` still pulses at the scheduled cycle.
- **Reset mid-access:** assert `rst` asynchronously in the second `ACCESS` cycle.
  - Immediately: `gnt=0`, strobes 0, `rdata=0`.
  - No `done` pulse.
  - After release with `req=100`, requester 0 is not favoured: requester 2 is granted at the first edge.
- **`MEM_LAT=1`:** `req=100`, `addr2=0x001`.
  - `ACCESS` lasts 1 cycle and `done=100` appears at T+2.
  - Back-to-back requests from the same port are served every 3 cycles.
